// File: rtl/param_rr_arbiter.sv
// rtl/param_rr_arbiter.sv - round-robin / fixed-priority arbiter with registered valid/ready output; ARB_TIMEOUT_EN adds a hold timeout

module param_rr_arbiter_capture #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDX_W-1:0] load_idx,
  output logic [WIDTH-1:0] data,
  output logic [IDX_W-1:0] idx
);

  // Capture the winner on a decision, otherwise keep the last winner visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      data <= load_data;
      idx  <= load_idx;
    end
  end

endmodule

module param_rr_arbiter #(
  parameter int    NUM_REQ = 4,
  parameter int    WIDTH   = 8,
  parameter string MODE    = "ROUND_ROBIN",
`ifdef ARB_TIMEOUT_EN
  parameter int    TIMEOUT = 16,
`endif
  localparam int   IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  // Any MODE other than "FIXED" falls back to round-robin
  localparam bit FIXED_MODE = (MODE == "FIXED");

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_found;
  logic             accept;
  logic             load;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] hold_cnt;
`endif

  assign accept   = (state == HOLD) && out_valid && out_ready;
  assign load     = (state == IDLE) && sel_found;
  assign next_ptr = (out_idx == IDX_W'(NUM_REQ - 1)) ? '0 : out_idx + 1'b1;

  // Scan requests starting at ptr (round-robin) or at 0 (fixed), wrapping modulo NUM_REQ
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, (FIXED_MODE ? {IDX_W{1'b0}} : ptr)} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Route the selected requester's data lane to the capture register
  always_comb begin
    sel_data = req_data[WIDTH-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant pulse to the captured winner in the cycle its transfer is accepted
  always_comb begin
    gnt          = '0;
    gnt[out_idx] = accept;
  end

  param_rr_arbiter_capture #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (sel_data),
    .load_idx  (sel_idx),
    .data      (out_data),
    .idx       (out_idx)
  );

  // Decide in IDLE, hold the captured word until accepted (or timed out), then release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_found) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        HOLD: begin
          if (accept) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            if (!FIXED_MODE) begin
              ptr <= next_ptr;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b1;
            if (!FIXED_MODE) begin
              ptr <= next_ptr;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_rr_arbiter.sv
// tb/tb_param_rr_arbiter.sv - self-checking bench for param_rr_arbiter (round-robin and fixed instances)

module tb_param_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, fx_req;
  logic [N*W-1:0] req_data, fx_req_data;
  logic           out_ready, fx_ready;
  logic [N-1:0]   gnt, fx_gnt;
  logic           out_valid, fx_valid;
  logic           busy, fx_busy;
  logic [W-1:0]   out_data, fx_data;
  logic [1:0]     out_idx, fx_idx;
`ifdef ARB_TIMEOUT_EN
  logic           timeout, fx_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MODE("ROUND_ROBIN")) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  param_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MODE("FIXED")) u_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (fx_req),
    .req_data  (fx_req_data),
    .gnt       (fx_gnt),
    .out_valid (fx_valid),
    .out_ready (fx_ready),
    .out_data  (fx_data),
    .out_idx   (fx_idx),
    .busy      (fx_busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (fx_timeout)
`endif
  );

  function automatic logic [N*W-1:0] lanes(input logic [W-1:0] base);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = base + W'(i);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req = '0; fx_req = '0; out_ready = 1'b0; fx_ready = 1'b0;
    req_data = '0; fx_req_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] expv;
    rst_n = 1'b0; req = 4'b1111; req_data = lanes(8'h10); out_ready = 1'b0;
    fx_req = 4'b1111; fx_req_data = lanes(8'h10); fx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, out_idx, out_data, gnt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_rr: got v=%b b=%b idx=%0d d=%h g=%b, need all zero", out_valid, busy, out_idx, out_data, gnt);
    end
    checks++;
    if ({fx_valid, fx_busy, fx_idx, fx_data, fx_gnt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_fx: got v=%b b=%b idx=%0d d=%h g=%b, need all zero", fx_valid, fx_busy, fx_idx, fx_data, fx_gnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    expv = {1'b1, 1'b1, 2'd0, 8'h10, 4'b0000};
    checks++;
    if ({out_valid, busy, out_idx, out_data, gnt} !== expv) begin
      errors++;
      $display("FAIL reset_release: got %h exp %h", {out_valid, busy, out_idx, out_data, gnt}, expv);
    end
  endtask

  task automatic test_rr_rotation();
    logic [15:0] expv;
    int e;
    do_reset();
    req = 4'b1111; req_data = lanes(8'h10); out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      e = i % N;
      expv = {1'b1, 1'b1, 2'(e), 8'h10 + 8'(e), 4'(1 << e)};
      checks++;
      if ({out_valid, busy, out_idx, out_data, gnt} !== expv) begin
        errors++;
        $display("FAIL rr_rotation[%0d]: got %h exp %h", i, {out_valid, busy, out_idx, out_data, gnt}, expv);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy, gnt} !== 6'b0) begin
        errors++;
        $display("FAIL rr_gap[%0d]: got v=%b b=%b g=%b, need 0/0/0000", i, out_valid, busy, gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] expv;
    do_reset();
    req = 4'b0100; req_data = lanes(8'hA0); out_ready = 1'b0;
    @(posedge clk); #1;
    req = 4'b1011; req_data = '1;
    expv = {1'b1, 1'b1, 2'd2, 8'hA2, 4'b0000};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({out_valid, busy, out_idx, out_data, gnt} !== expv) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got %h exp %h", c, {out_valid, busy, out_idx, out_data, gnt}, expv);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; req = 4'b0011;
    #1;
    checks++;
    if ({out_valid, gnt} !== 5'b1_0100) begin
      errors++;
      $display("FAIL backpressure_gnt: got v=%b g=%b, need 1/0100", out_valid, gnt);
    end
    @(posedge clk); #1;
    expv = {1'b0, 1'b0, 2'd2, 8'hA2, 4'b0000};
    checks++;
    if ({out_valid, busy, out_idx, out_data, gnt} !== expv) begin
      errors++;
      $display("FAIL backpressure_release: got %h exp %h", {out_valid, busy, out_idx, out_data, gnt}, expv);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] expv;
    int          seq [3] = '{0, 1, 0};
    req_data = lanes(8'h20);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expv = {1'b1, 1'b1, 2'(seq[i]), 8'h20 + 8'(seq[i]), 4'(1 << seq[i])};
      checks++;
      if ({out_valid, busy, out_idx, out_data, gnt} !== expv) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h exp %h", i, {out_valid, busy, out_idx, out_data, gnt}, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fixed();
    logic [15:0] expv;
    do_reset();
    fx_req = 4'b1010; fx_req_data = lanes(8'h30); fx_ready = 1'b1;
    expv = {1'b1, 1'b1, 2'd1, 8'h31, 4'b0010};
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      checks++;
      if ({fx_valid, fx_busy, fx_idx, fx_data, fx_gnt} !== expv) begin
        errors++;
        $display("FAIL fixed[%0d]: got %h exp %h", t, {fx_valid, fx_busy, fx_idx, fx_data, fx_gnt}, expv);
      end
      @(posedge clk); #1;
    end
    fx_ready = 1'b0;
    @(posedge clk); #1;
    fx_req = 4'b1000;
    #1;
    expv = {1'b1, 1'b1, 2'd1, 8'h31, 4'b0000};
    checks++;
    if ({fx_valid, fx_busy, fx_idx, fx_data, fx_gnt} !== expv) begin
      errors++;
      $display("FAIL fixed_drop_hold: got %h exp %h", {fx_valid, fx_busy, fx_idx, fx_data, fx_gnt}, expv);
    end
    fx_ready = 1'b1;
    #1;
    checks++;
    if (fx_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL fixed_drop_gnt: got %b exp 0010", fx_gnt);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    expv = {1'b1, 1'b1, 2'd3, 8'h33, 4'b1000};
    checks++;
    if ({fx_valid, fx_busy, fx_idx, fx_data, fx_gnt} !== expv) begin
      errors++;
      $display("FAIL fixed_idx3: got %h exp %h", {fx_valid, fx_busy, fx_idx, fx_data, fx_gnt}, expv);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req = 4'b0001; req_data = lanes(8'h50); out_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, out_idx, out_data, gnt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_hold: got v=%b b=%b idx=%0d d=%h g=%b, need all zero", out_valid, busy, out_idx, out_data, gnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy, gnt} !== 6'b0) begin
        errors++;
        $display("FAIL idle_ready_ignored[%0d]: got v=%b b=%b g=%b", c, out_valid, busy, gnt);
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0100; req_data = lanes(8'h40); out_ready = 1'b0;
    @(posedge clk); #1;
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({out_valid, timeout, gnt} !== 6'b10_0000) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got v=%b t=%b g=%b", c, out_valid, timeout, gnt);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_valid, busy, timeout, gnt} !== 7'b001_0000) begin
      errors++;
      $display("FAIL timeout_pulse: got v=%b b=%b t=%b g=%b, need 0/0/1/0000", out_valid, busy, timeout, gnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, timeout, out_idx} !== 4'b10_11) begin
      errors++;
      $display("FAIL timeout_next: got v=%b t=%b idx=%0d, need 1/0/3", out_valid, timeout, out_idx);
    end
    repeat (15) @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, timeout, gnt} !== 6'b10_1000) begin
      errors++;
      $display("FAIL timeout_last_accept: got v=%b t=%b g=%b, need 1/0/1000", out_valid, timeout, gnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, timeout} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_precedence: got v=%b t=%b, need 0/0", out_valid, timeout);
    end
  endtask
`endif

  task automatic test_random();
    bit             m_pend [2];
    int             m_idx  [2];
    int             m_ptr  [2];
    logic [W-1:0]   m_data [2];
`ifdef ARB_TIMEOUT_EN
    int             m_cnt  [2];
    bit             m_to   [2];
`endif
    logic [N-1:0]   p_req  [2];
    logic [N*W-1:0] p_data [2];
    logic           p_rdy  [2];
    int             base, c;
    bit             found;
    logic [15:0]    act, expv;
    do_reset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_data[u] = '0;
`ifdef ARB_TIMEOUT_EN
      m_cnt[u] = 0; m_to[u] = 0;
`endif
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      req         = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      fx_req      = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      req_data    = (N*W)'($urandom);
      fx_req_data = (N*W)'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      fx_ready    = ($urandom_range(0, 3) != 0);
      #1;
      p_req[0] = req;    p_data[0] = req_data;    p_rdy[0] = out_ready;
      p_req[1] = fx_req; p_data[1] = fx_req_data; p_rdy[1] = fx_ready;
      for (int u = 0; u < 2; u++) begin
        expv = {m_pend[u], m_pend[u], 2'(m_idx[u]), m_data[u],
                (m_pend[u] && p_rdy[u]) ? 4'(1 << m_idx[u]) : 4'b0000};
        act  = (u == 0) ? {out_valid, busy, out_idx, out_data, gnt}
                        : {fx_valid, fx_busy, fx_idx, fx_data, fx_gnt};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %h exp %h", u, cyc, act, expv);
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (((u == 0) ? timeout : fx_timeout) !== m_to[u]) begin
          errors++;
          $display("FAIL random_timeout inst%0d cyc%0d: got %b exp %b", u, cyc, (u == 0) ? timeout : fx_timeout, m_to[u]);
        end
`endif
      end
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
`ifdef ARB_TIMEOUT_EN
        m_to[u] = 0;
`endif
        if (m_pend[u]) begin
          if (p_rdy[u]) begin
            m_pend[u] = 0;
            if (u == 0) m_ptr[u] = (m_idx[u] + 1) % N;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            m_cnt[u]++;
            if (m_cnt[u] == 16) begin
              m_pend[u] = 0;
              m_to[u]   = 1;
              if (u == 0) m_ptr[u] = (m_idx[u] + 1) % N;
            end
          end
`endif
        end else if (p_req[u] != '0) begin
          base  = (u == 0) ? m_ptr[u] : 0;
          found = 0;
          for (int k = 0; k < N; k++) begin
            c = (base + k) % N;
            if (!found && p_req[u][c]) begin
              found     = 1;
              m_idx[u]  = c;
              m_data[u] = p_data[u][c*W +: W];
            end
          end
          m_pend[u] = 1;
`ifdef ARB_TIMEOUT_EN
          m_cnt[u] = 0;
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_backpressure();
    test_wrap();
    test_fixed();
    test_reset_mid_hold();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/param_rr_arbiter.md
Name: param_rr_arbiter

Overview:
Arbiter that shares one WIDTH-bit output datapath between NUM_REQ requesters.
- Arbitration policy is chosen by a string parameter: round-robin or fixed priority.
- The winner's data is captured into an output register and presented with a valid/ready handshake.
- The winner receives a one-cycle grant pulse when the transfer is accepted.
- Sits in front of a width-parameterised consumer instantiated with a parameter override.

Parameters:
- NUM_REQ, 4, number of requesters (≥1).
- WIDTH, 8, data width per requester.
- MODE, "ROUND_ROBIN", arbitration policy; "FIXED" selects fixed priority, any other string means round-robin.
- TIMEOUT, 16, backpressure cycle limit; used only when ARB_TIMEOUT_EN is defined.
- IDX_W, localparam, max(1, clog2(NUM_REQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request bit per requester; held high until the matching gnt pulse.
- req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot acknowledge pulse, one cycle, at transfer acceptance.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_data  output  WIDTH  captured winner data.
- out_idx  output  IDX_W  index of the current winner.
- busy  output  1  high in HOLD state.
- timeout  output  1  one-cycle pulse; present only with ARB_TIMEOUT_EN.

Behaviour:
- One clock; reset is asynchronous, active-low, on rst_n.
- Reset values: out_valid=0, gnt=0, out_data=0, out_idx=0, busy=0, pointer ptr=0, state=IDLE, timeout=0.
- FSM states: IDLE, HOLD.
- IDLE with req==0: remain in IDLE, outputs hold their last values, out_valid=0.
- IDLE with req!=0: select winner w and register the following at the clock edge:
  - out_data = req_data[w];
  - out_idx = w;
  - out_valid = 1;
  - busy = 1;
  - go to HOLD.
- Decision-to-valid latency is 1 cycle.
- HOLD: out_valid, out_data and out_idx stay stable. req and req_data are ignored; captured data is not updated.
- HOLD, accept (out_valid & out_ready): in the same cycle gnt[w]=1 combinationally (gnt = {NUM_REQ{accept}} & onehot(out_idx)).
  - Next edge: out_valid=0, busy=0, state=IDLE.
  - Round-robin mode only: ptr = (w+1) mod NUM_REQ.
- Throughput: at most one transfer per 2 cycles, because IDLE always inserts a decision cycle.
- Round-robin selection: first set req bit scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
- FIXED selection: lowest set index wins; ptr is not updated.
- A requester that drops req while in HOLD still has its transfer completed; the captured data is sent.
- NUM_REQ=1: always grants index 0; out_idx is 1 bit, constant 0.
- Asserting rst_n low mid-HOLD immediately clears all outputs; the transfer is lost and no gnt is issued.
- out_ready in IDLE is ignored.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in HOLD, cleared on entry.
  - If TIMEOUT consecutive HOLD cycles pass without acceptance, at the next edge: out_valid=0, busy=0, state=IDLE, timeout pulses 1 for one cycle, no gnt is issued.
  - In round-robin mode ptr advances past w.
  - Acceptance on the final cycle takes precedence over timeout.
- Undefined: no counter, no timeout port; HOLD waits indefinitely.

Test Plan:
1. Reset: hold rst_n=0 with req=4'b1111 → out_valid=0, gnt=0, out_idx=0, busy=0, out_data=0. Release → out_valid=1 one cycle later with out_idx=0.
2. Round-robin rotation: NUM_REQ=4, WIDTH=8, req=4'b1111 held, req_data[i]=8'h10+i, out_ready=1.
   - out_idx sequence 0,1,2,3,0; out_data 10,11,12,13,10.
   - out_valid high every other cycle; gnt pulses 0001, 0010, 0100, 1000.
3. Backpressure: winner 2 in HOLD, out_ready=0 for 5 cycles, req_data changed meanwhile.
   - out_data, out_idx=2 and out_valid stay stable; gnt=0.
   - out_ready=1 → single gnt=4'b0100 pulse, out_valid=0 next cycle.
4. Wrap-around: after a grant to index 2 (ptr=3), req=4'b0011 → winner 0, then winner 1.
5. FIXED: MODE="FIXED", req=4'b1010 held, out_ready=1 → out_idx=1 on every transfer. Drop req[1] → out_idx=3.
6. Timeout: ARB_TIMEOUT_EN defined, TIMEOUT=16, out_ready=0 in HOLD for 16 cycles.
   - timeout pulses for 1 cycle; out_valid drops; gnt stays 0; next winner is index w+1.
   - Separately, assert rst_n=0 mid-HOLD → immediate clear, no gnt.
